// File: rtl/mem_axi_pkg.sv
// Shared types and constants for the native-to-AXI4-Lite memory master.
package mem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [2:0]  PROT_DATA   = 3'b000;
  localparam logic [2:0]  PROT_INSTR  = 3'b100;
  localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;

  function automatic logic [2:0] prot_for(input logic instr);
    return instr ? PROT_INSTR : PROT_DATA;
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Response wait counter: restarts on clear, counts while enabled, flags expiry
// once TIMEOUT_CYCLES cycles have elapsed since the last clear.
module bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The count is stale on the clearing cycle, so expiry is masked there.
  assign expire = enable && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_axi_master.sv
// Single-outstanding native request to AXI4-Lite master.
// Optional response timeout enabled by defining MEM_AXI_MASTER_TIMEOUT_EN.
module mem_axi_master
  import mem_axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic        req_instr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_ready,
  output logic [31:0] req_rdata,
  output logic        req_err,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic        tmo_expire;

`ifdef MEM_AXI_MASTER_TIMEOUT_EN
  state_t state_prev;
  logic   tmo_clear;
  logic   tmo_enable;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_prev <= IDLE;
    else     state_prev <= state;
  end

  assign tmo_clear  = (state != state_prev);
  assign tmo_enable = (state == RD_ADDR) || (state == RD_DATA) ||
                      (state == WR_ADDR_DATA) || (state == WR_RESP);

  bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_expire = 1'b0;
`endif

  assign mem_axi_awaddr = addr_q;
  assign mem_axi_awprot = PROT_DATA;
  assign mem_axi_wdata  = wdata_q;
  assign mem_axi_wstrb  = wstrb_q;
  assign mem_axi_araddr = addr_q;
  assign mem_axi_arprot = prot_for(instr_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      instr_q         <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      req_ready       <= 1'b0;
      req_err         <= 1'b0;
      req_rdata       <= '0;
    end else if (tmo_expire) begin
      // Abandon the bus transaction and report the error to the requester.
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      req_ready       <= 1'b1;
      req_err         <= 1'b1;
      if (wstrb_q == 4'b0000) req_rdata <= RD_ERR_DATA;
      state           <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            instr_q <= req_instr;
            if (req_wstrb == 4'b0000) begin
              mem_axi_arvalid <= 1'b1;
              state           <= RD_ADDR;
            end else begin
              mem_axi_awvalid <= 1'b1;
              mem_axi_wvalid  <= 1'b1;
              state           <= WR_ADDR_DATA;
            end
          end
        end
        RD_ADDR: begin
          if (mem_axi_arready) begin
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b1;
            state           <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_axi_rvalid) begin
            mem_axi_rready <= 1'b0;
            req_rdata      <= mem_axi_rdata;
            req_ready      <= 1'b1;
            state          <= DONE;
          end
        end
        WR_ADDR_DATA: begin
          // A channel whose valid is already low has completed its handshake.
          if (mem_axi_awready) mem_axi_awvalid <= 1'b0;
          if (mem_axi_wready)  mem_axi_wvalid  <= 1'b0;
          if ((!mem_axi_awvalid || mem_axi_awready) &&
              (!mem_axi_wvalid  || mem_axi_wready)) begin
            mem_axi_bready <= 1'b1;
            state          <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (mem_axi_bvalid) begin
            mem_axi_bready <= 1'b0;
            req_ready      <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b0;
          req_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_master.sv
// Scoreboard bench for mem_axi_master with a delay-programmable AXI4-Lite slave.
module tb_mem_axi_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_instr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, req_err;
  logic [31:0] req_rdata;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  always #5 CLK = ~CLK;

  mem_axi_master #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_err(req_err),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: each ready/valid rises after its channel has waited *_dly cycles.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] slv_rdata = '0;
  int cyc = 0;

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    ar_cnt <= (mem_axi_arvalid && !mem_axi_arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (mem_axi_rready  && !mem_axi_rvalid)  ? r_cnt + 1  : 0;
    aw_cnt <= (mem_axi_awvalid && !mem_axi_awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (mem_axi_wvalid  && !mem_axi_wready)  ? w_cnt + 1  : 0;
    b_cnt  <= (mem_axi_bready  && !mem_axi_bvalid)  ? b_cnt + 1  : 0;
  end

  assign mem_axi_arready = mem_axi_arvalid && (ar_cnt >= ar_dly);
  assign mem_axi_rvalid  = mem_axi_rready  && (r_cnt  >= r_dly);
  assign mem_axi_awready = mem_axi_awvalid && (aw_cnt >= aw_dly);
  assign mem_axi_wready  = mem_axi_wvalid  && (w_cnt  >= w_dly);
  assign mem_axi_bvalid  = mem_axi_bready  && (b_cnt  >= b_dly);
  assign mem_axi_rdata   = slv_rdata;

  logic [34:0] arq[$];
  logic [31:0] awq[$];
  logic [35:0] wq[$];
  logic [32:0] sbq[$];

  int aw_total = 0, w_total = 0, proto_err = 0;
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [34:0] p_ar = '0;
  logic [31:0] p_aw = '0;
  logic [35:0] p_w  = '0;

  always @(negedge CLK) begin : mon
    int v;
    logic [34:0] ea;
    logic [35:0] ew;
    v = 0;
    if (RST) begin
      p_arv <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
    end else begin
      if (mem_axi_arvalid && mem_axi_arready) begin
        if (arq.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          ea = arq.pop_front();
          chk("araddr", mem_axi_araddr, ea[34:3]);
          chk("arprot", mem_axi_arprot, ea[2:0]);
        end
      end
      if (mem_axi_awvalid && mem_axi_awready) begin
        if (awq.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", mem_axi_awaddr, awq.pop_front());
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        if (wq.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          ew = wq.pop_front();
          chk("wdata", mem_axi_wdata, ew[35:4]);
          chk("wstrb", mem_axi_wstrb, ew[3:0]);
        end
      end
      if (p_arv && !p_arr && (!mem_axi_arvalid || {mem_axi_araddr, mem_axi_arprot} != p_ar)) v++;
      if (p_awv && !p_awr && (!mem_axi_awvalid || mem_axi_awaddr != p_aw)) v++;
      if (p_wv && !p_wr && (!mem_axi_wvalid || {mem_axi_wdata, mem_axi_wstrb} != p_w)) v++;
      if ((mem_axi_arvalid && mem_axi_rready) ||
          ((mem_axi_awvalid || mem_axi_wvalid) && mem_axi_bready)) v++;
      proto_err <= proto_err + v;
      aw_total  <= aw_total + (mem_axi_awvalid ? 1 : 0);
      w_total   <= w_total + (mem_axi_wvalid ? 1 : 0);
      p_arv <= mem_axi_arvalid; p_arr <= mem_axi_arready; p_ar <= {mem_axi_araddr, mem_axi_arprot};
      p_awv <= mem_axi_awvalid; p_awr <= mem_axi_awready; p_aw <= mem_axi_awaddr;
      p_wv  <= mem_axi_wvalid;  p_wr  <= mem_axi_wready;  p_w  <= {mem_axi_wdata, mem_axi_wstrb};
    end
  end

  logic [31:0] last_rd = '0;
  int aw_hi, w_hi;

  task automatic do_req(input string name, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic exp_err, input int exp_lat, input bit drop);
    int t0, lat, aw0, w0;
    bit seen;
    logic [32:0] e;
    @(negedge CLK);
    req_instr = instr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1;
    if (!exp_err) begin
      if (wstrb == 4'b0000) arq.push_back({addr, instr ? 3'b100 : 3'b000});
      else begin
        awq.push_back(addr);
        wq.push_back({wdata, wstrb});
      end
    end
    if (exp_err) last_rd = (wstrb == 4'b0000) ? 32'hFFFF_FFFF : last_rd;
    else if (wstrb == 4'b0000) last_rd = slv_rdata;
    sbq.push_back({exp_err, last_rd});
    aw0 = aw_total; w0 = w_total;
    t0 = cyc + 1;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge CLK);
      if (drop) req_valid = 1'b0;
      if (req_ready) seen = 1;
    end
    lat = cyc - t0 + 1;
    req_valid = 1'b0;
    e = sbq.pop_front();
    aw_hi = aw_total - aw0;
    w_hi  = w_total - w0;
    if (!seen) chk({name, "_ready_wait"}, 0, 1);
    else begin
      chk({name, "_rdata"}, req_rdata, e[31:0]);
      chk({name, "_err"}, req_err, e[32]);
      if (exp_lat > 0) chk({name, "_latency"}, lat, exp_lat);
    end
    @(negedge CLK);
    chk({name, "_ready_pulse"}, req_ready, 0);
  endtask

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_instr = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(negedge CLK);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_valids", {mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid}, 0);
    chk("rst_readies", {mem_axi_rready, mem_axi_bready}, 0);
    chk("rst_araddr", mem_axi_araddr, 0);
    chk("rst_wstrb", mem_axi_wstrb, 0);
    RST = 1'b0;

    slv_rdata = 32'hDEAD_BEEF;
    do_req("rd_zero_wait", 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 1'b0, 3, 1'b0);

    aw_dly = 2;
    do_req("wr_aw_delay", 1'b0, 32'h1000_0004, 32'h1234_5678, 4'b0011, 1'b0, 5, 1'b0);
    chk("wr_aw_delay_awvalid_cycles", aw_hi, 3);
    chk("wr_aw_delay_wvalid_cycles", w_hi, 1);
    aw_dly = 0;

    slv_rdata = 32'h0000_0013;
    do_req("ifetch", 1'b1, 32'h0000_0000, 32'h0, 4'b0000, 1'b0, 3, 1'b0);

    ar_dly = 1; r_dly = 2; slv_rdata = 32'hA5A5_5A5A;
    do_req("rd_slow", 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0, 6, 1'b0);
    ar_dly = 0; r_dly = 0;

    do_req("wr_same_cycle", 1'b0, 32'h2000_0010, 32'hCAFE_0001, 4'b1111, 1'b0, 3, 1'b0);
    chk("wr_same_cycle_awvalid_cycles", aw_hi, 1);

    w_dly = 3; b_dly = 1;
    do_req("wr_w_delay", 1'b0, 32'h2000_0020, 32'h0BAD_F00D, 4'b1100, 1'b0, 7, 1'b0);
    chk("wr_w_delay_wvalid_cycles", w_hi, 4);
    w_dly = 0; b_dly = 0;

    slv_rdata = 32'h5555_AAAA;
    do_req("rd_drop_valid", 1'b0, 32'h0000_0044, 32'h0, 4'b0000, 1'b0, 3, 1'b1);

    // Reset while waiting for read data.
    r_dly = 1000;
    @(negedge CLK);
    req_instr = 1'b0; req_addr = 32'h0000_0200; req_wstrb = 4'b0000; req_valid = 1'b1;
    arq.push_back({32'h0000_0200, 3'b000});
    for (int n = 0; n < 20 && !mem_axi_rready; n++) @(negedge CLK);
    chk("rstmid_in_rd_data", mem_axi_rready, 1);
    RST = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rstmid_arvalid", mem_axi_arvalid, 0);
    chk("rstmid_rready", mem_axi_rready, 0);
    chk("rstmid_rdata", req_rdata, 0);
    repeat (3) @(negedge CLK);
    chk("rstmid_no_ready", req_ready, 0);
    RST = 1'b0;
    r_dly = 0;
    last_rd = '0;
    slv_rdata = 32'hCAFE_F00D;
    do_req("rd_after_rst", 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 1'b0, 3, 1'b0);

`ifdef MEM_AXI_MASTER_TIMEOUT_EN
    ar_dly = 100000;
    do_req("rd_timeout", 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 1'b1, 0, 1'b0);
    chk("rd_timeout_arvalid", mem_axi_arvalid, 0);
    ar_dly = 0;
`endif

    repeat (2) @(negedge CLK);
    chk("protocol", proto_err, 0);
    chk("queues_drained", arq.size() + awq.size() + wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_axi_master.md
MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, response wait limit in cycles (used only with MEM_AXI_MASTER_TIMEOUT_EN).
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  native request pending; held until req_ready.
REQ-005 req_instr  input  1  instruction fetch; drives arprot[2].
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  write data.
REQ-008 req_wstrb  input  4  byte strobes; 4'b0000 = read.
REQ-009 req_ready  output  1  one-cycle completion pulse.
REQ-010 req_rdata  output  32  read data, valid with req_ready.
REQ-011 req_err  output  1  error flag, valid with req_ready.
REQ-012 mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  out/in/out/out  write address channel.
REQ-013 mem_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  write data channel.
REQ-014 mem_axi_bvalid/bready  in/out  write response channel.
REQ-015 mem_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  out/in/out/out  read address channel.
REQ-016 mem_axi_rvalid/rready/rdata[31:0]  in/out/in  read data channel.

Function
REQ-017 States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
REQ-018 IDLE: req_valid=1 and req_wstrb=0 -> RD_ADDR; req_valid=1 and req_wstrb!=0 -> WR_ADDR_DATA; request fields registered on that edge.
REQ-019 RD_ADDR: arvalid=1 with registered address; arprot={req_instr,2'b00}; on arvalid&&arready -> RD_DATA, arvalid low next cycle.
REQ-020 RD_DATA: rready=1; on rvalid -> capture rdata into req_rdata, -> DONE.
REQ-021 WR_ADDR_DATA: awvalid and wvalid asserted together; each drops independently after its own handshake; -> WR_RESP when both accepted, including same-cycle acceptance.
REQ-022 WR_RESP: bready=1; on bvalid -> DONE.
REQ-023 DONE: req_ready=1 for exactly one cycle, -> IDLE; a new request is not accepted in DONE.
REQ-024 Latency: minimum 3 cycles from req_valid sample to req_ready with zero-wait slave (accept, handshake, response).
REQ-025 AXI valids never deasserted before handshake; address/data/strobe/prot stable while valid high.
REQ-026 rready and bready high only in RD_DATA and WR_RESP respectively.
REQ-027 req_rdata holds last captured read value; unchanged by writes.
REQ-028 req_err=0 on every completion when MEM_AXI_MASTER_TIMEOUT_EN is undefined.
REQ-029 req_valid deassertion mid-transaction is ignored; transaction completes.

Reset
REQ-030 On RST=1, asynchronously: state=IDLE; all AXI valid/ready outputs 0; req_ready=0; req_err=0; req_rdata=0; registered address/data/strobe=0.
REQ-031 RST mid-transaction abandons it without completion pulse; after release, first request starts fresh from IDLE.

Configuration
REQ-032 Macro MEM_AXI_MASTER_TIMEOUT_EN defined: counter runs in RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, cleared on state entry; reaching TIMEOUT_CYCLES drops all valids/readies, -> DONE with req_err=1, req_rdata=32'hFFFFFFFF for reads.
REQ-033 Macro undefined: no counter logic; master waits indefinitely.

Structure
REQ-034 Package mem_axi_pkg holds state enum, AXI prot constants (PROT_DATA=3'b000, PROT_INSTR=3'b100), and read-error value 32'hFFFFFFFF.
REQ-035 Sub-module bus_timeout (clear, enable, expire output) instantiated only under MEM_AXI_MASTER_TIMEOUT_EN.

Verification
REQ-036 Read, zero-wait slave: addr 0x00000040, rdata 0xDEADBEEF -> araddr=0x40, req_ready 3 cycles after request, req_rdata=0xDEADBEEF, req_err=0.
REQ-037 Write, awready delayed 2 cycles, wready immediate: addr 0x10000004, data 0x12345678, wstrb 4'b0011 -> wvalid drops after 1 cycle, awvalid held 3 cycles, single req_ready after bvalid.
REQ-038 Instruction fetch at 0x00000000 -> arprot=3'b100; data read -> arprot=3'b000.
REQ-039 RST asserted in RD_DATA -> arvalid/rready 0 immediately, no req_ready; next read 0x00000008 completes normally.
REQ-040 Timeout (macro defined, TIMEOUT_CYCLES=8), slave never asserts arready -> req_ready with req_err=1, req_rdata=0xFFFFFFFF, arvalid low after expiry.
